// File: rtl/control_encoder_pkg.sv
// Shared symbol constants, FSM state encoding and FIFO geometry for the link control encoder.
package control_encoder_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;  // comma / idle
    localparam logic [7:0] K27_7 = 8'hFB;  // start of frame
    localparam logic [7:0] K29_7 = 8'hFD;  // end of frame
    localparam logic [7:0] K28_0 = 8'h1C;  // skip

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_WIDTH = 9;

    typedef enum logic [2:0] {
        ST_ALIGN = 3'd0,
        ST_IDLE  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_END   = 3'd4
    } state_t;

endpackage

// File: rtl/control_encoder_fifo_enlace.sv
// 4-entry x 9-bit {ultimo, datos} FIFO between the requester and the encoder FSM.
module fifo_enlace
    import control_encoder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [FIFO_WIDTH-1:0] din,
    output logic [FIFO_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic [2:0]            count
);

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [FIFO_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic [2:0]            count_q, count_d;
    logic                  do_push, do_pop;

    assign full  = (count_q == 3'(FIFO_DEPTH));
    assign empty = (count_q == 3'd0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Full is taken from the registered count, so a same-cycle pop never frees a slot for a push.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/control_encoder.sv
// Frames FIFO payload bytes with K-symbols (align, idle, start, end) for an 8b/10b encoder.
// Optional CONTROL_ENCODER_SKIP_EN replaces every SKIP_PERIOD-th idle K28.5 with K28.0.
module control_encoder
    import control_encoder_pkg::*;
#(
    parameter int unsigned ALIGN_COUNT = 4,
    parameter int unsigned SKIP_PERIOD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic [7:0] datos_in,
    input  logic       valido,
    input  logic       ultimo,
    output logic       listo,
    output logic [7:0] datos_enc,
    output logic       K_enc,
    output logic       enb_enc,
    output logic       subdesbordo
);

    if (ALIGN_COUNT < 1 || ALIGN_COUNT > 255 || SKIP_PERIOD < 1 || SKIP_PERIOD > 256) begin : g_param_check
        $error("control_encoder: ALIGN_COUNT or SKIP_PERIOD out of range");
    end

    localparam logic [7:0] ALIGN_LAST = 8'(ALIGN_COUNT - 1);

    logic       fifo_push, fifo_pop;
    logic [8:0] fifo_dout;
    logic       fifo_full, fifo_empty;
    logic [2:0] fifo_count;

    state_t     state_q, state_d;
    logic [7:0] align_q, align_d;
    logic [7:0] datos_q, datos_d;
    logic       k_q, k_d;
    logic       enb_enc_q, enb_enc_d;
    logic       subd_q, subd_d;

    assign listo     = !fifo_full && !rst;
    assign fifo_push = valido && listo && enb;
    assign fifo_pop  = enb && (state_q == ST_DATA) && !fifo_empty;

    fifo_enlace u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({ultimo, datos_in}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef CONTROL_ENCODER_SKIP_EN
    localparam logic [7:0] SKIP_LAST = 8'(SKIP_PERIOD - 1);
    logic [7:0] skip_q, skip_d;
`endif

    always_comb begin
        state_d   = state_q;
        align_d   = align_q;
        datos_d   = datos_q;
        k_d       = k_q;
        enb_enc_d = 1'b0;
        subd_d    = 1'b0;
`ifdef CONTROL_ENCODER_SKIP_EN
        skip_d    = skip_q;
`endif
        if (enb) begin
            enb_enc_d = 1'b1;
            case (state_q)
                ST_ALIGN: begin
                    datos_d = K28_5;
                    k_d     = 1'b1;
                    if (align_q == ALIGN_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        align_d = align_q + 8'd1;
                    end
                end
                ST_IDLE: begin
                    datos_d = K28_5;
                    k_d     = 1'b1;
                    if (fifo_count != 3'd0) begin
                        state_d = ST_START;
                    end
`ifdef CONTROL_ENCODER_SKIP_EN
                    // A pending frame wins over SKIP and restarts the idle run.
                    if (fifo_count != 3'd0) begin
                        skip_d = '0;
                    end else if (skip_q == SKIP_LAST) begin
                        datos_d = K28_0;
                        skip_d  = '0;
                    end else begin
                        skip_d = skip_q + 8'd1;
                    end
`endif
                end
                ST_START: begin
                    datos_d = K27_7;
                    k_d     = 1'b1;
                    state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (fifo_count != 3'd0) begin
                        datos_d = fifo_dout[7:0];
                        k_d     = 1'b0;
                        if (fifo_dout[8]) begin
                            state_d = ST_END;
                        end
                    end else begin
                        datos_d = K28_5;
                        k_d     = 1'b1;
                        subd_d  = 1'b1;
                    end
                end
                ST_END: begin
                    datos_d = K29_7;
                    k_d     = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_ALIGN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ALIGN;
            align_q   <= '0;
            datos_q   <= '0;
            k_q       <= 1'b0;
            enb_enc_q <= 1'b0;
            subd_q    <= 1'b0;
`ifdef CONTROL_ENCODER_SKIP_EN
            skip_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            align_q   <= align_d;
            datos_q   <= datos_d;
            k_q       <= k_d;
            enb_enc_q <= enb_enc_d;
            subd_q    <= subd_d;
`ifdef CONTROL_ENCODER_SKIP_EN
            skip_q    <= skip_d;
`endif
        end
    end

    assign datos_enc   = datos_q;
    assign K_enc       = k_q;
    assign enb_enc     = enb_enc_q;
    assign subdesbordo = subd_q;

endmodule

// File: tb/tb_control_encoder.sv
// Directed bench for control_encoder (default build): alignment, framing, underrun, stall, reset, backpressure.
module tb_control_encoder;

    logic       clk = 1'b0;
    logic       rst, enb, valido, ultimo;
    logic [7:0] datos_in;
    logic       listo, K_enc, enb_enc, subdesbordo;
    logic [7:0] datos_enc;

    int         n_cmp = 0;
    int         n_err = 0;
    logic       listo_pre;

    control_encoder #(.ALIGN_COUNT(4), .SKIP_PERIOD(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .enb         (enb),
        .datos_in    (datos_in),
        .valido      (valido),
        .ultimo      (ultimo),
        .listo       (listo),
        .datos_enc   (datos_enc),
        .K_enc       (K_enc),
        .enb_enc     (enb_enc),
        .subdesbordo (subdesbordo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packs {enb_enc, subdesbordo, K_enc, datos_enc} into one comparison.
    task automatic check_sym(input string tag, input logic [7:0] d, input logic k,
                             input logic en, input logic sd);
        check(tag, {21'd0, enb_enc, subdesbordo, K_enc, datos_enc}, {21'd0, en, sd, k, d});
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic u);
        valido   = v;
        datos_in = d;
        ultimo   = u;
        @(negedge clk);
        listo_pre = listo;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] got[$];
        int         idx;
        bit         done;

        rst = 1'b1; enb = 1'b1; valido = 1'b0; ultimo = 1'b0; datos_in = 8'h00;
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        check_sym("rst_out", 8'h00, 0, 0, 0);
        check("rst_listo", listo, 1'b0);

        // Alignment then idle with no traffic
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(0, 8'h00, 0);
            check_sym("align", 8'hBC, 1, 1, 0);
        end
        check("listo_empty", listo, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(0, 8'h00, 0);
            check_sym("idle", 8'hBC, 1, 1, 0);
        end

        // Three-byte frame
        step(1, 8'h01, 0); check_sym("f3_idle0", 8'hBC, 1, 1, 0);
        step(1, 8'h02, 0); check_sym("f3_idle1", 8'hBC, 1, 1, 0);
        step(1, 8'h03, 1); check_sym("f3_start", 8'hFB, 1, 1, 0);
        step(0, 8'h00, 0); check_sym("f3_b01", 8'h01, 0, 1, 0);
        step(0, 8'h00, 0); check_sym("f3_b02", 8'h02, 0, 1, 0);
        step(0, 8'h00, 0); check_sym("f3_b03", 8'h03, 0, 1, 0);
        step(0, 8'h00, 0); check_sym("f3_end", 8'hFD, 1, 1, 0);
        step(0, 8'h00, 0); check_sym("f3_idle2", 8'hBC, 1, 1, 0);

        // Underrun inside a frame
        step(1, 8'hAA, 0); check_sym("ur_idle0", 8'hBC, 1, 1, 0);
        step(0, 8'h00, 0); check_sym("ur_idle1", 8'hBC, 1, 1, 0);
        step(0, 8'h00, 0); check_sym("ur_start", 8'hFB, 1, 1, 0);
        step(0, 8'h00, 0); check_sym("ur_bAA", 8'hAA, 0, 1, 0);
        step(0, 8'h00, 0); check_sym("ur_fill0", 8'hBC, 1, 1, 1);
        step(0, 8'h00, 0); check_sym("ur_fill1", 8'hBC, 1, 1, 1);
        step(1, 8'h55, 1); check_sym("ur_fill2", 8'hBC, 1, 1, 1);
        step(0, 8'h00, 0); check_sym("ur_b55", 8'h55, 0, 1, 0);
        step(0, 8'h00, 0); check_sym("ur_end", 8'hFD, 1, 1, 0);
        step(0, 8'h00, 0); check_sym("ur_idle2", 8'hBC, 1, 1, 0);

        // enb stall mid-frame
        step(1, 8'h20, 0); check_sym("st_idle0", 8'hBC, 1, 1, 0);
        step(1, 8'h21, 0); check_sym("st_idle1", 8'hBC, 1, 1, 0);
        step(1, 8'h22, 1); check_sym("st_start", 8'hFB, 1, 1, 0);
        step(0, 8'h00, 0); check_sym("st_b20", 8'h20, 0, 1, 0);
        enb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(0, 8'h00, 0);
            check_sym("st_hold", 8'h20, 0, 0, 0);
        end
        enb = 1'b1;
        step(0, 8'h00, 0); check_sym("st_b21", 8'h21, 0, 1, 0);
        step(0, 8'h00, 0); check_sym("st_b22", 8'h22, 0, 1, 0);
        step(0, 8'h00, 0); check_sym("st_end", 8'hFD, 1, 1, 0);
        step(0, 8'h00, 0); check_sym("st_idle2", 8'hBC, 1, 1, 0);

        // Reset mid-frame discards the rest of the frame
        step(1, 8'h30, 0); check_sym("mr_idle0", 8'hBC, 1, 1, 0);
        step(1, 8'h31, 0); check_sym("mr_idle1", 8'hBC, 1, 1, 0);
        step(0, 8'h00, 0); check_sym("mr_start", 8'hFB, 1, 1, 0);
        step(0, 8'h00, 0); check_sym("mr_b30", 8'h30, 0, 1, 0);
        rst = 1'b1;
        step(0, 8'h00, 0); check_sym("mr_rst", 8'h00, 0, 0, 0);
        check("mr_listo", listo, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(0, 8'h00, 0);
            check_sym("mr_realign", 8'hBC, 1, 1, 0);
        end

        // Six bytes offered during alignment: backpressure and ordering
        rst = 1'b1;
        step(0, 8'h00, 0);
        rst = 1'b0;
        idx  = 0;
        done = 1'b0;
        for (int cyc = 1; cyc <= 30 && !done; cyc++) begin
            step(idx < 6, 8'(8'h40 + idx), idx == 5);
            if (valido && listo_pre) idx++;
            if (cyc == 4) check("bp_listo_full", listo, 1'b0);
            if (enb_enc && !K_enc) got.push_back(datos_enc);
            if (K_enc && datos_enc == 8'hFD) done = 1'b1;
        end
        valido = 1'b0;
        check("bp_done", done, 1'b1);
        check("bp_pushed", idx, 6);
        check("bp_count", got.size(), 6);
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            check("bp_byte", got[i], 8'(8'h40 + i));
        end
        step(0, 8'h00, 0); check_sym("bp_idle", 8'hBC, 1, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/control_encoder.md
CONTROL_ENCODER -- requirements
Module: control_encoder

Interface
REQ-001 Parameter ALIGN_COUNT, default 4: number of K28.5 comma symbols emitted after reset, range 1..255.
REQ-002 Parameter SKIP_PERIOD, default 16: IDLE cycles between SKIP symbols; only used with CONTROL_ENCODER_SKIP_EN.
REQ-003 Port clk, input, 1: single clock; all logic is posedge clk.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port enb, input, 1: global advance enable; when low, all state holds.
REQ-006 Port datos_in, input, 8: payload byte from requester.
REQ-007 Port valido, input, 1: datos_in/ultimo valid.
REQ-008 Port ultimo, input, 1: byte is last of frame.
REQ-009 Port listo, output, 1: FIFO can accept a byte.
REQ-010 Port datos_enc, output, 8: byte to encoder entradas.
REQ-011 Port K_enc, output, 1: control-symbol flag to encoder K.
REQ-012 Port enb_enc, output, 1: encoder enable.
REQ-013 Port subdesbordo, output, 1: one-cycle pulse on mid-frame FIFO underrun.

Function
REQ-014 Symbol constants: K28.5=8'hBC, K27.7=8'hFB (start), K29.7=8'hFD (end), K28.0=8'h1C (skip), all with K_enc=1; payload bytes with K_enc=0.
REQ-015 Internal FIFO: 4 entries x 9 bits {ultimo, datos}, 3-bit occupancy count.
REQ-016 listo = (count != 4) and not rst; derived from the registered count only.
REQ-017 Push occurs when valido && listo && enb at posedge.
REQ-018 A pop in the same cycle as full does not make room for a push in that cycle.
REQ-019 Pop only in DATA state with count != 0.
REQ-020 Simultaneous push and pop with count in 1..3 leaves count unchanged.
REQ-021 FSM states: ALIGN, IDLE, START, DATA, END.
REQ-022 ALIGN: emit K28.5 each enabled cycle; after ALIGN_COUNT symbols go to IDLE; pushes are accepted during ALIGN.
REQ-023 IDLE: emit K28.5; if count != 0, next state START.
REQ-024 START: emit K27.7 for exactly one cycle, then DATA.
REQ-025 DATA with count != 0: pop the head and emit its byte with K_enc=0; if its ultimo=1, next state END.
REQ-026 DATA with count == 0 (underrun): emit K28.5 filler, pulse subdesbordo, stay in DATA.
REQ-027 END: emit K29.7 for one cycle, then IDLE.
REQ-028 A byte pushed at edge t with FSM in IDLE: START appears at outputs after edge t+2, the byte after edge t+3 (all outputs registered).
REQ-029 Back-to-back frames: END is followed directly by IDLE (at least one K28.5) before the next START.
REQ-030 enb low: FSM, counters, FIFO and outputs hold their values; enb_enc=0; no push or pop.
REQ-031 enb high: enb_enc=1 one cycle later, registered with datos_enc.

Reset
REQ-032 rst high at posedge: state=ALIGN, align counter=0, FIFO emptied, skip counter=0.
REQ-033 Reset output values: datos_enc=8'h00, K_enc=0, enb_enc=0, subdesbordo=0; listo=0 while rst is high.
REQ-034 rst asserted mid-frame discards FIFO contents and the partial frame, with no END symbol emitted.

Configuration
REQ-035 With CONTROL_ENCODER_SKIP_EN defined, a counter of consecutive IDLE emissions replaces every SKIP_PERIOD-th K28.5 in IDLE with K28.0.
REQ-036 Under CONTROL_ENCODER_SKIP_EN, the skip counter resets to 0 on leaving IDLE.
REQ-037 Under CONTROL_ENCODER_SKIP_EN, a pending START takes priority over SKIP.
REQ-038 Without CONTROL_ENCODER_SKIP_EN, IDLE emits only K28.5 and the skip counter logic is absent.

Structure
REQ-039 Shared package/include control_encoder_pkg holds the K-symbol constants and FSM state encodings; the encoder test benches reuse it.
REQ-040 The FIFO is one sub-module, fifo_enlace (depth 4, width 9), with push, pop, full, empty and count outputs.

Verification
REQ-041 Reset, enb=1, no valido -> exactly 4 cycles of BC/K=1, then continuous BC/K=1; enb_enc=1; subdesbordo never asserted.
REQ-042 Push 8'h01, 8'h02, 8'h03 (ultimo on 03) in IDLE -> FB/K, 01, 02, 03 with K=0, then FD/K, then BC/K.
REQ-043 Push 6 bytes back-to-back -> listo drops after 4 are held; all 6 are emitted in order with no loss or duplication.
REQ-044 Push 8'hAA (no ultimo), wait 3 cycles, push 8'h55 with ultimo -> FB, AA, BC filler with subdesbordo pulses, 55, FD.
REQ-045 Hold enb=0 for 5 cycles mid-frame -> outputs frozen, enb_enc=0; the frame resumes intact afterwards.
REQ-046 Assert rst mid-frame -> next cycle outputs 00/K=0/enb_enc=0, FIFO empty, then the ALIGN sequence; with CONTROL_ENCODER_SKIP_EN, long idle shows 1C/K every 16th IDLE symbol.
